// File: rtl/cal_pkg.sv
// Shared types, BCD constants and helpers for the calendar set controller and the counter chain.
package cal_pkg;

    typedef enum logic [2:0] {
        StRun      = 3'd0,
        StSetYear  = 3'd1,
        StSetMonth = 3'd2,
        StSetDay   = 3'd3,
        StCommit   = 3'd4
    } cal_state_e;

    localparam logic [7:0] YearMin       = 8'h00;
    localparam logic [7:0] YearMax       = 8'h99;
    localparam logic [7:0] MonthMin      = 8'h01;
    localparam logic [7:0] MonthMax      = 8'h12;
    localparam logic [7:0] DayMin        = 8'h01;
    localparam logic [7:0] Days31        = 8'h31;
    localparam logic [7:0] Days30        = 8'h30;
    localparam logic [7:0] DaysFebLeap   = 8'h29;
    localparam logic [7:0] DaysFebCommon = 8'h28;

    localparam logic [3:0] BlinkNone  = 4'b0000;
    localparam logic [3:0] BlinkLeft  = 4'b1100;
    localparam logic [3:0] BlinkRight = 4'b0011;

    // Two-digit BCD increment; caller handles wrap at the field maximum.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [6:0] bcd_to_bin(input logic [7:0] v);
        return (7'(v[7:4]) * 7'd10) + 7'(v[3:0]);
    endfunction

endpackage

// File: rtl/calendar_set_ctrl_if.sv
// Control/data bundle between the set controller and the counter chain, buttons and display path.
interface calendar_set_ctrl_if;

    logic       tick_blink;
    logic       btn_set;
    logic       btn_inc;
    logic       run_disp_sel;
    logic [7:0] cur_year;
    logic [7:0] cur_month;
    logic [7:0] cur_day;

    logic       run_en;
    logic       ld_en;
    logic [7:0] ld_year;
    logic [7:0] ld_month;
    logic [7:0] ld_day;
    logic       disp_sel;
    logic       shadow_sel;
    logic [3:0] blink_mask;

    modport slave (
        input  tick_blink, btn_set, btn_inc, run_disp_sel, cur_year, cur_month, cur_day,
        output run_en, ld_en, ld_year, ld_month, ld_day, disp_sel, shadow_sel, blink_mask
    );

    modport master (
        output tick_blink, btn_set, btn_inc, run_disp_sel, cur_year, cur_month, cur_day,
        input  run_en, ld_en, ld_year, ld_month, ld_day, disp_sel, shadow_sel, blink_mask
    );

endinterface

// File: rtl/cal_max_day.sv
// Month length lookup in BCD; February follows the binary year mod 4 leap rule (2000 is leap).
module cal_max_day
    import cal_pkg::*;
(
    input  logic [7:0] i_month,
    input  logic [7:0] i_year,
    output logic [7:0] o_max_day
);

    logic [6:0] w_year_bin;
    logic       w_leap;

    assign w_year_bin = bcd_to_bin(i_year);
    assign w_leap     = (w_year_bin[1:0] == 2'b00);

    always_comb begin
        o_max_day = Days31;
        case (i_month)
            8'h02:                      o_max_day = w_leap ? DaysFebLeap : DaysFebCommon;
            8'h04, 8'h06, 8'h09, 8'h11: o_max_day = Days30;
            default:                    o_max_day = Days31;
        endcase
    end

endmodule

// File: rtl/calendar_set_ctrl.sv
// Date-setting FSM: freezes the calendar chain, edits a BCD shadow date field by field with
// blinking feedback, then issues a one-cycle parallel load or abandons the edit on timeout.
module calendar_set_ctrl
    import cal_pkg::*;
#(
    parameter int unsigned TIMEOUT_TICKS = 20,
    parameter int unsigned TW            = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    calendar_set_ctrl_if.slave   bus
);

    cal_state_e r_state, w_state_nxt;
    logic [7:0] r_year, w_year_nxt;
    logic [7:0] r_month, w_month_nxt;
    logic [7:0] r_day, w_day_nxt;
    logic       r_blink_phase, w_blink_phase_nxt;
    logic [TW-1:0] r_timeout, w_timeout_nxt;

    logic [7:0] w_max_day;
    logic [7:0] w_day_clamped;

    cal_max_day u_max_day (
        .i_month   (r_month),
        .i_year    (r_year),
        .o_max_day (w_max_day)
    );

    assign w_day_clamped = (r_day > w_max_day) ? w_max_day : r_day;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StRun;
            r_year        <= YearMin;
            r_month       <= MonthMin;
            r_day         <= DayMin;
            r_blink_phase <= 1'b0;
            r_timeout     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_year        <= w_year_nxt;
            r_month       <= w_month_nxt;
            r_day         <= w_day_nxt;
            r_blink_phase <= w_blink_phase_nxt;
            r_timeout     <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_year_nxt        = r_year;
        w_month_nxt       = r_month;
        w_day_nxt         = r_day;
        w_blink_phase_nxt = r_blink_phase;
        w_timeout_nxt     = r_timeout;

        case (r_state)
            StRun: begin
                w_blink_phase_nxt = 1'b0;
                w_timeout_nxt     = '0;
                if (bus.btn_set) begin
                    w_year_nxt  = bus.cur_year;
                    w_month_nxt = bus.cur_month;
                    w_day_nxt   = bus.cur_day;
                    w_state_nxt = StSetYear;
                end
            end

            StSetYear, StSetMonth, StSetDay: begin
                // Priority: btn_set over btn_inc, any button over tick_blink.
                if (bus.btn_set) begin
                    w_blink_phase_nxt = 1'b0;
                    w_timeout_nxt     = '0;
                    case (r_state)
                        StSetYear:  w_state_nxt = StSetMonth;
                        StSetMonth: begin
                            w_state_nxt = StSetDay;
                            w_day_nxt   = w_day_clamped;
                        end
                        default:    w_state_nxt = StCommit;
                    endcase
                end else if (bus.btn_inc) begin
                    w_blink_phase_nxt = 1'b0;
                    w_timeout_nxt     = '0;
                    case (r_state)
                        StSetYear:
                            w_year_nxt = (r_year == YearMax) ? YearMin : bcd_inc(r_year);
                        StSetMonth:
                            w_month_nxt = (r_month >= MonthMax) ? MonthMin : bcd_inc(r_month);
                        default:
                            w_day_nxt = (r_day >= w_max_day) ? DayMin : bcd_inc(r_day);
                    endcase
                end else if (bus.tick_blink) begin
                    w_blink_phase_nxt = ~r_blink_phase;
                    if (r_timeout == TW'(TIMEOUT_TICKS - 1)) begin
                        w_state_nxt       = StRun;
                        w_timeout_nxt     = '0;
                        w_blink_phase_nxt = 1'b0;
                    end else begin
                        w_timeout_nxt = r_timeout + TW'(1);
                    end
                end
            end

            StCommit: begin
                w_state_nxt       = StRun;
                w_blink_phase_nxt = 1'b0;
                w_timeout_nxt     = '0;
            end

            default: begin
                w_state_nxt       = StRun;
                w_blink_phase_nxt = 1'b0;
                w_timeout_nxt     = '0;
            end
        endcase
    end

    logic       w_run_en;
    logic       w_ld_en;
    logic       w_disp_sel;
    logic       w_shadow_sel;
    logic [3:0] w_blink_mask;

    always_comb begin
        w_run_en     = 1'b0;
        w_ld_en      = 1'b0;
        w_disp_sel   = 1'b0;
        w_shadow_sel = 1'b1;
        w_blink_mask = BlinkNone;

        case (r_state)
            StRun: begin
                w_run_en     = 1'b1;
                w_disp_sel   = bus.run_disp_sel;
                w_shadow_sel = 1'b0;
            end
            StSetYear: begin
                w_disp_sel   = 1'b1;
                w_blink_mask = BlinkRight & {4{r_blink_phase}};
            end
            StSetMonth: w_blink_mask = BlinkLeft & {4{r_blink_phase}};
            StSetDay:   w_blink_mask = BlinkRight & {4{r_blink_phase}};
            StCommit:   w_ld_en = 1'b1;
            default: begin
                w_run_en     = 1'b1;
                w_shadow_sel = 1'b0;
            end
        endcase
    end

    assign bus.run_en     = w_run_en;
    assign bus.ld_en      = w_ld_en;
    assign bus.disp_sel   = w_disp_sel;
    assign bus.shadow_sel = w_shadow_sel;
    assign bus.blink_mask = w_blink_mask;
    assign bus.ld_year    = r_year;
    assign bus.ld_month   = r_month;
    assign bus.ld_day     = w_day_clamped;

endmodule

// File: tb/tb_calendar_set_ctrl.sv
// Directed bench for calendar_set_ctrl: reset, full edit, clamping, wraps, timeout, priority, reset.
module tb_calendar_set_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   ld_cnt;

    calendar_set_ctrl_if bus ();

    calendar_set_ctrl #(
        .TIMEOUT_TICKS (20),
        .TW            (5)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.ld_en === 1'b1) ld_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_set();
        bus.btn_set = 1'b1;
        step();
        bus.btn_set = 1'b0;
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            bus.btn_inc = 1'b1;
            step();
            bus.btn_inc = 1'b0;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick_blink = 1'b1;
            step();
            bus.tick_blink = 1'b0;
        end
    endtask

    task automatic set_cur(input logic [7:0] y, input logic [7:0] m, input logic [7:0] d);
        bus.cur_year  = y;
        bus.cur_month = m;
        bus.cur_day   = d;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        ld_cnt   = 0;
        rst_n    = 1'b0;
        bus.tick_blink   = 1'b0;
        bus.btn_set      = 1'b0;
        bus.btn_inc      = 1'b0;
        bus.run_disp_sel = 1'b1;
        set_cur(8'h25, 8'h04, 8'h15);

        // Reset state
        step();
        step();
        check_eq("rst_run_en", 32'(bus.run_en), 1);
        check_eq("rst_ld_en", 32'(bus.ld_en), 0);
        check_eq("rst_shadow_sel", 32'(bus.shadow_sel), 0);
        check_eq("rst_blink", 32'(bus.blink_mask), 0);
        check_eq("rst_shadow", {8'h0, bus.ld_year, bus.ld_month, bus.ld_day}, 32'h00_0101);
        rst_n = 1'b1;
        step();
        step();
        check_eq("run_disp_sel1", 32'(bus.disp_sel), 1);
        bus.run_disp_sel = 1'b0;
        #1;
        check_eq("run_disp_sel0", 32'(bus.disp_sel), 0);
        bus.run_disp_sel = 1'b1;

        // Full edit: 25/04/15 -> 28/02/01
        press_set();
        check_eq("sy_run_en", 32'(bus.run_en), 0);
        check_eq("sy_shadow_sel", 32'(bus.shadow_sel), 1);
        check_eq("sy_disp_sel", 32'(bus.disp_sel), 1);
        check_eq("sy_capture", {8'h0, bus.ld_year, bus.ld_month, bus.ld_day}, 32'h25_0415);
        check_eq("sy_blink0", 32'(bus.blink_mask), 0);
        ticks(1);
        check_eq("sy_blink1", 32'(bus.blink_mask), 32'b0011);
        press_inc(3);
        check_eq("sy_blink_btn", 32'(bus.blink_mask), 0);
        check_eq("sy_year28", 32'(bus.ld_year), 32'h28);
        press_set();
        check_eq("sm_disp_sel", 32'(bus.disp_sel), 0);
        ticks(1);
        check_eq("sm_blink1", 32'(bus.blink_mask), 32'b1100);
        press_inc(10);
        check_eq("sm_month02", 32'(bus.ld_month), 32'h02);
        press_set();
        check_eq("sd_day15", 32'(bus.ld_day), 32'h15);
        ticks(1);
        check_eq("sd_blink1", 32'(bus.blink_mask), 32'b0011);
        press_inc(14);
        check_eq("sd_day29", 32'(bus.ld_day), 32'h29);
        press_inc(1);
        check_eq("sd_day_wrap", 32'(bus.ld_day), 32'h01);
        press_set();
        check_eq("cm_ld_en", 32'(bus.ld_en), 1);
        check_eq("cm_run_en", 32'(bus.run_en), 0);
        check_eq("cm_ld_vals", {8'h0, bus.ld_year, bus.ld_month, bus.ld_day}, 32'h28_0201);
        step();
        check_eq("cm_after_run_en", 32'(bus.run_en), 1);
        check_eq("cm_after_ld_en", 32'(bus.ld_en), 0);
        check_eq("cm_ld_cnt1", ld_cnt, 1);

        // Day clamp: 31 Jan -> Feb, common year 23 then leap year 24
        set_cur(8'h23, 8'h01, 8'h31);
        press_set();
        press_set();
        press_inc(1);
        press_set();
        check_eq("clamp23", 32'(bus.ld_day), 32'h28);
        press_set();
        check_eq("clamp23_ld", {8'h0, bus.ld_year, bus.ld_month, bus.ld_day}, 32'h23_0228);
        step();
        set_cur(8'h24, 8'h01, 8'h31);
        press_set();
        press_set();
        press_inc(1);
        press_set();
        check_eq("clamp24", 32'(bus.ld_day), 32'h29);
        press_set();
        check_eq("clamp24_ld_en", 32'(bus.ld_en), 1);
        step();

        // Wraps: year 99, month 12, BCD day 09 -> 10; buttons ignored in COMMIT
        set_cur(8'h99, 8'h12, 8'h09);
        press_set();
        press_inc(1);
        check_eq("wrap_year", 32'(bus.ld_year), 32'h00);
        press_set();
        press_inc(1);
        check_eq("wrap_month", 32'(bus.ld_month), 32'h01);
        press_set();
        press_inc(1);
        check_eq("bcd_day_carry", 32'(bus.ld_day), 32'h10);
        press_set();
        check_eq("wrap_ld_vals", {8'h0, bus.ld_year, bus.ld_month, bus.ld_day}, 32'h00_0110);
        press_set();
        check_eq("commit_ign_btn", 32'(bus.run_en), 1);
        step();
        check_eq("commit_ign_btn2", 32'(bus.shadow_sel), 0);
        set_cur(8'h09, 8'h04, 8'h30);
        press_set();
        press_inc(1);
        check_eq("bcd_year_carry", 32'(bus.ld_year), 32'h10);
        press_set();
        press_set();
        press_inc(1);
        check_eq("wrap_day30", 32'(bus.ld_day), 32'h01);
        press_set();
        step();
        check_eq("ld_cnt5", ld_cnt, 5);

        // Timeout with no buttons
        set_cur(8'h25, 8'h04, 8'h15);
        press_set();
        ticks(19);
        check_eq("to19_run_en", 32'(bus.run_en), 0);
        check_eq("to19_blink", 32'(bus.blink_mask), 32'b0011);
        ticks(1);
        check_eq("to20_run_en", 32'(bus.run_en), 1);
        check_eq("to20_shadow_sel", 32'(bus.shadow_sel), 0);

        // Timeout restarted by btn_inc arriving together with tick 19
        press_set();
        ticks(18);
        bus.btn_inc    = 1'b1;
        bus.tick_blink = 1'b1;
        step();
        bus.btn_inc    = 1'b0;
        bus.tick_blink = 1'b0;
        check_eq("to_inc_year", 32'(bus.ld_year), 32'h26);
        check_eq("to_inc_blink", 32'(bus.blink_mask), 0);
        ticks(19);
        check_eq("to_restart19", 32'(bus.run_en), 0);
        ticks(1);
        check_eq("to_restart20", 32'(bus.run_en), 1);
        check_eq("to_no_ld", ld_cnt, 5);

        // btn_set beats btn_inc; reset mid-edit
        press_set();
        bus.btn_set = 1'b1;
        bus.btn_inc = 1'b1;
        step();
        bus.btn_set = 1'b0;
        bus.btn_inc = 1'b0;
        check_eq("simul_disp_sel", 32'(bus.disp_sel), 0);
        check_eq("simul_year", 32'(bus.ld_year), 32'h25);
        check_eq("simul_shadow_sel", 32'(bus.shadow_sel), 1);
        press_set();
        check_eq("sd_before_rst", 32'(bus.run_en), 0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_run_en", 32'(bus.run_en), 1);
        check_eq("midrst_shadow", {8'h0, bus.ld_year, bus.ld_month, bus.ld_day}, 32'h00_0101);
        step();
        rst_n = 1'b1;
        step();
        step();
        check_eq("final_ld_cnt", ld_cnt, 5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
